// File: rtl/alu_defs_pkg.sv
// alu_defs: shared definitions for the ALU arbiter slice.
//  W, AFW     default operand/result and function-code widths
//  state_t    arbiter FSM encoding (IDLE/EXEC/RESP)
//  AF_*       ALU function codes, used by benches only (never decoded by the arbiter)
package alu_defs;
  localparam int W   = 32;
  localparam int AFW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] AF_ADD = 4'b0000;
  localparam logic [3:0] AF_SRL = 4'b0110;
  localparam logic [3:0] AF_AND = 4'b1000;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant.
//  valid[1:0]  requesters asserting
//  ptr         preferred requester when both are valid
//  grant[1:0]  one-hot winner, or 0 when nothing is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
//  req0_*/req1_*   request channels (valid/ready, i, a, b, af)
//  rsp0_*/rsp1_*   response handshakes; rsp_res/zero/neg/ovf shared by both
//  alu_*           operand outputs to / result inputs from the ALU instance
//  busy            FSM not in IDLE
//  op_count        completed response handshakes (wrapping)
// One op in flight: IDLE (grant) -> EXEC (ALU evaluates registered operands)
// -> RESP (registered result held until the winner consumes it).
module alu_arbiter
  import alu_defs::*;
#(
  parameter int W    = alu_defs::W,
  parameter int AFW  = alu_defs::AFW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_i,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic [AFW-1:0]  req0_af,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_i,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  input  logic [AFW-1:0]  req1_af,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [W-1:0]    rsp_res,
  output logic            rsp_zero,
  output logic            rsp_neg,
  output logic            rsp_ovf,
  output logic            alu_i,
  output logic [W-1:0]    alu_srca,
  output logic [W-1:0]    alu_srcb,
  output logic [AFW-1:0]  alu_af,
  input  logic [W-1:0]    alu_res,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_ovf,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);
  typedef struct packed {
    logic           i;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [AFW-1:0] af;
  } op_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         neg;
    logic         ovf;
  } res_t;

  state_t     state, nstate;
  logic       rr_ptr;
  logic       tag;
  op_t        op_q;
  res_t       res_q;
  op_t  [1:0] req_op;
  logic [1:0] grant;
  logic [1:0] req_rdy;
  logic [1:0] rsp_vld;
  logic       accept;
  logic       rsp_hs;

  assign req_op[0] = '{i: req0_i, a: req0_a, b: req0_b, af: req0_af};
  assign req_op[1] = '{i: req1_i, a: req1_a, b: req1_b, af: req1_af};

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grants are only offered while idle; ready is the grant itself.
  assign req_rdy    = (state == IDLE) ? grant : 2'b00;
  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];
  assign accept     = |req_rdy;

  // Only the tagged channel sees valid; the other channel's ready is masked off.
  assign rsp_vld    = (state == RESP) ? (tag ? 2'b10 : 2'b01) : 2'b00;
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp_hs     = |(rsp_vld & {rsp1_ready, rsp0_ready});

  assign alu_i    = op_q.i;
  assign alu_srca = op_q.a;
  assign alu_srcb = op_q.b;
  assign alu_af   = op_q.af;

  assign rsp_res  = res_q.res;
  assign rsp_zero = res_q.zero;
  assign rsp_neg  = res_q.neg;
  assign rsp_ovf  = res_q.ovf;

  assign busy = (state != IDLE);

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = EXEC;
      EXEC:    nstate = RESP;
      RESP:    if (rsp_hs) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      tag      <= 1'b0;
      op_q     <= '0;
      res_q    <= '0;
      op_count <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        op_q   <= req_rdy[1] ? req_op[1] : req_op[0];
        tag    <= req_rdy[1];
        rr_ptr <= ~req_rdy[1];
      end
      if (state == EXEC)
        res_q <= '{res: alu_res, zero: alu_zero, neg: alu_neg, ovf: alu_ovf};
      if (rsp_hs)
        op_count <= op_count + CNTW'(1);
    end
  end
endmodule
